// File: rtl/bcd_pkg.sv
// bcd_pkg: shared widths, FSM states and digit helpers for the serial BCD adder.
package bcd_pkg;
    localparam int BCD_W = 4;

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    function automatic logic [BCD_W-1:0] nines_comp(input logic [BCD_W-1:0] d);
        return 4'd9 - d;
    endfunction

    function automatic logic bcd_invalid(input logic [BCD_W-1:0] d);
        return d > 4'd9;
    endfunction
endpackage

// File: rtl/bcd_serial_adder_if.sv
// bcd_serial_adder_if: operand/result handshake bundle; err exists only with BCD_INVALID_CHECK_EN.
interface bcd_serial_adder_if #(parameter int DIGITS = 4);
    logic                in_valid;
    logic                in_ready;
    logic [4*DIGITS-1:0] a;
    logic [4*DIGITS-1:0] b;
    logic                ci;
    logic                sub;
    logic                out_valid;
    logic                out_ready;
    logic [4*DIGITS-1:0] sum;
    logic                co;
`ifdef BCD_INVALID_CHECK_EN
    logic                err;
    modport master (output in_valid, a, b, ci, sub, out_ready, input in_ready, out_valid, sum, co, err);
    modport slave  (input in_valid, a, b, ci, sub, out_ready, output in_ready, out_valid, sum, co, err);
`else
    modport master (output in_valid, a, b, ci, sub, out_ready, input in_ready, out_valid, sum, co);
    modport slave  (input in_valid, a, b, ci, sub, out_ready, output in_ready, out_valid, sum, co);
`endif
endinterface

// File: rtl/bcd_digit_add.sv
// bcd_digit_add: one decimal digit add with +6 correction, shared across all digit cycles.
module bcd_digit_add
    import bcd_pkg::*;
(
    input  logic [BCD_W-1:0] a_d,
    input  logic [BCD_W-1:0] b_d,
    input  logic             c_in,
    output logic [BCD_W-1:0] s_d,
    output logic             c_out
);
    logic [BCD_W:0] t;

    always_comb begin
        t     = {1'b0, a_d} + {1'b0, b_d} + {4'd0, c_in};
        c_out = t > 5'd9;
        s_d   = c_out ? t[BCD_W-1:0] + 4'd6 : t[BCD_W-1:0];
    end
endmodule

// File: rtl/bcd_serial_adder.sv
// bcd_serial_adder: digit-serial packed-BCD add/subtract, LSD first, one digit per clock.
// Define BCD_INVALID_CHECK_EN to add the sticky non-BCD operand flag (err).
module bcd_serial_adder
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input logic               clk,
    input logic               rst_n,
    bcd_serial_adder_if.slave bus
);
    localparam int W  = BCD_W * DIGITS;
    localparam int CW = $clog2(DIGITS);

    state_t             state, state_nx;
    logic [CW-1:0]      cnt;
    logic [W-1:0]       a_sr, b_sr, b_in;
    logic               c, c_out, last, accept;
    logic [BCD_W-1:0]   s_d;

    bcd_digit_add u_digit (
        .a_d  (a_sr[BCD_W-1:0]),
        .b_d  (b_sr[BCD_W-1:0]),
        .c_in (c),
        .s_d  (s_d),
        .c_out(c_out)
    );

    always_comb begin
        last     = cnt == CW'(DIGITS - 1);
        accept   = state == IDLE && bus.in_valid;
        state_nx = state == IDLE ? (bus.in_valid ? ADD : IDLE)
                 : state == ADD  ? (last ? DONE : ADD)
                 : (bus.out_ready ? IDLE : DONE);
        b_in = bus.b;
        for (int i = 0; i < DIGITS; i++)
            b_in[i*BCD_W +: BCD_W] = bus.sub ? nines_comp(bus.b[i*BCD_W +: BCD_W]) : bus.b[i*BCD_W +: BCD_W];
    end

    assign bus.in_ready  = state == IDLE;
    assign bus.out_valid = state == DONE;

`ifdef BCD_INVALID_CHECK_EN
    logic err, bad;

    always_comb begin
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++)
            bad = bad | bcd_invalid(bus.a[i*BCD_W +: BCD_W]) | bcd_invalid(bus.b[i*BCD_W +: BCD_W]);
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            err <= 1'b0;
        else if (accept)
            err <= bad;

    assign bus.err = err;
`endif

    // Result digits shift into the top of a_sr as operand digits leave the bottom.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            a_sr    <= '0;
            b_sr    <= '0;
            c       <= 1'b0;
            bus.sum <= '0;
            bus.co  <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                a_sr <= bus.a;
                b_sr <= b_in;
                c    <= bus.sub | bus.ci;
                cnt  <= '0;
            end else if (state == ADD) begin
                a_sr <= {s_d, a_sr[W-1:BCD_W]};
                b_sr <= b_sr >> BCD_W;
                c    <= c_out;
                cnt  <= last ? '0 : cnt + 1'b1;
                if (last) begin
                    bus.sum <= {s_d, a_sr[W-1:BCD_W]};
                    bus.co  <= c_out;
                end
            end
        end
    end
endmodule

// File: tb/tb_bcd_serial_adder.sv
// tb_bcd_serial_adder: directed + random scoreboard bench for the 4-digit serial BCD adder.
module tb_bcd_serial_adder;
    typedef struct packed {
        logic [15:0] sum;
        logic        co;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    bcd_serial_adder_if #(.DIGITS(4)) bus ();
    bcd_serial_adder #(.DIGITS(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int bcd2i(input logic [15:0] v);
        int r = 0;
        for (int i = 3; i >= 0; i--) r = r * 10 + int'(v[i*4 +: 4]);
        return r;
    endfunction

    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic ci, input logic sub);
        exp_t e;
        int   s;
        s = sub ? 10000 + bcd2i(a) - bcd2i(b) : bcd2i(a) + bcd2i(b) + int'(ci);
        e.co = s >= 10000;
        s = s % 10000;
        for (int i = 0; i < 4; i++) begin
            e.sum[i*4 +: 4] = 4'(s % 10);
            s = s / 10;
        end
        e.err = 1'b0;
        return e;
    endfunction

    task automatic start(input logic [15:0] ta, input logic [15:0] tb_v, input logic tci, input logic tsub, input exp_t e);
        int n = 0;
        @(negedge clk);
        bus.a = ta; bus.b = tb_v; bus.ci = tci; bus.sub = tsub; bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk("accept_timeout", 32'(n), 32'd0);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        q.push_back(e);
    endtask

    task automatic drain(input int hold);
        int   lat = 0;
        exp_t e;
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk);
            #1 lat++;
        end
        chk("latency", 32'(lat), 32'd4);
        if (q.size() == 0) begin
            chk("scoreboard_empty", 32'd0, 32'd1);
            return;
        end
        e = q.pop_front();
        chk("sum", 32'(bus.sum), 32'(e.sum));
        chk("co", 32'(bus.co), 32'(e.co));
`ifdef BCD_INVALID_CHECK_EN
        chk("err", 32'(bus.err), 32'(e.err));
`endif
        bus.in_valid = 1'b1; bus.a = 16'h1111; bus.b = 16'h2222; bus.sub = 1'b0;
        repeat (hold) begin
            @(posedge clk);
            #1;
            chk("hold_sum", 32'(bus.sum), 32'(e.sum));
            chk("hold_co", 32'(bus.co), 32'(e.co));
            chk("hold_valid", 32'(bus.out_valid), 32'd1);
            chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        chk("post_out_valid", 32'(bus.out_valid), 32'd0);
        chk("post_in_ready", 32'(bus.in_ready), 32'd1);
        chk("post_sum_kept", 32'(bus.sum), 32'(e.sum));
    endtask

    task automatic txn(input logic [15:0] ta, input logic [15:0] tb_v, input logic tci, input logic tsub, input int hold);
        start(ta, tb_v, tci, tsub, model(ta, tb_v, tci, tsub));
        drain(hold);
    endtask

    initial begin
        logic [15:0] ra, rb;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.a = '0; bus.b = '0; bus.ci = 1'b0; bus.sub = 1'b0;
        #12;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_sum", 32'(bus.sum), 32'd0);
        chk("rst_co", 32'(bus.co), 32'd0);
`ifdef BCD_INVALID_CHECK_EN
        chk("rst_err", 32'(bus.err), 32'd0);
`endif
        @(negedge clk) rst_n = 1'b1;

        txn(16'h1234, 16'h8766, 1'b0, 1'b0, 0);
        txn(16'h9999, 16'h0000, 1'b1, 1'b0, 0);
        txn(16'h0045, 16'h0037, 1'b0, 1'b0, 0);
        txn(16'h0500, 16'h0123, 1'b1, 1'b1, 0);
        txn(16'h0123, 16'h0500, 1'b0, 1'b1, 0);
        txn(16'h4321, 16'h1111, 1'b0, 1'b0, 5);

        // Abort in the second ADD cycle; the pending expectation is discarded.
        start(16'h5555, 16'h4444, 1'b0, 1'b0, model(16'h5555, 16'h4444, 1'b0, 1'b0));
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_in_ready", 32'(bus.in_ready), 32'd1);
        chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
        chk("abort_sum", 32'(bus.sum), 32'd0);
        chk("abort_co", 32'(bus.co), 32'd0);
        q.delete();
        @(negedge clk) rst_n = 1'b1;
        txn(16'h0999, 16'h0001, 1'b0, 1'b0, 1);
        txn(16'h0000, 16'h0001, 1'b0, 1'b1, 0);

`ifdef BCD_INVALID_CHECK_EN
        start(16'h00A0, 16'h0001, 1'b0, 1'b0, '{sum: 16'h0100, co: 1'b0, err: 1'b1});
        drain(0);
        txn(16'h0010, 16'h0020, 1'b0, 1'b0, 0);
`endif

        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < 4; i++) begin
                ra[i*4 +: 4] = 4'($urandom_range(0, 9));
                rb[i*4 +: 4] = 4'($urandom_range(0, 9));
            end
            txn(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
